gate_selftest_seq: RTL and testbench
====================================

GATE_SELFTEST_SEQ -- requirements
Module: gate_selftest_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, legal range 1..15: the number of cycles each vector is held before dut_y is sampled.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to run one exhaustive test; accepted only in IDLE.
REQ-005 op  input  3  expected function, sampled on accept: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 BUF_A, 7 INV_A.
REQ-006 dut_a, dut_b  output  1 each  registered stimulus to the gate under test.
REQ-007 dut_y  input  1  response of the gate under test, treated as combinational from dut_a/dut_b.
REQ-008 busy  output  1  high from accept until the end of DONE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 pass  output  1  1 when the last run had zero mismatches; held until the next accept.
REQ-011 err_cnt  output  3  mismatch count of the last run (0..4); held until the next accept.

Function
REQ-012 FSM states: IDLE, WAIT, SAMPLE, DONE.
REQ-013 IDLE with start=1: latch op, clear err_cnt and pass, set idx=0, go to WAIT.
REQ-014 Vector mapping: dut_a=idx[1], dut_b=idx[0]; both stay 0 in IDLE and DONE.
REQ-015 WAIT lasts exactly SETTLE_CYCLES cycles (down-counter), then goes to SAMPLE.
REQ-016 SAMPLE lasts 1 cycle:
- compare dut_y against the golden value for (latched op, dut_a, dut_b);
- a mismatch increments err_cnt;
- idx<3 -> idx+1 and back to WAIT;
- idx==3 -> DONE.
REQ-017 DONE lasts 1 cycle: done=1, pass=(err_cnt==0), busy=1; then IDLE.
REQ-018 Latency: done is high in the cycle 4*(SETTLE_CYCLES+1)+1 after the accepting edge (13 for the default).
REQ-019 start while busy is ignored; a start that is still high in the cycle after DONE starts a new run.
REQ-020 Changes on op after accept have no effect on the current run.
REQ-021 err_cnt cannot exceed 4; it needs no saturation logic.

Reset
REQ-022 rst_n low forces immediately: state=IDLE, idx=0, counter=0, dut_a=dut_b=0, busy=0, done=0, pass=0, err_cnt=0.
REQ-023 Reset during a run aborts it with no done pulse; the next start after release runs normally.

Configuration
REQ-024 Macro GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN controls first-failure capture.
- Defined: adds output fail_valid (1 bit) and output fail_vec (2 bits).
- On the first mismatch of a run, fail_vec latches idx and fail_valid is set.
- Both are cleared on accept and on reset, and are held after done.
- Undefined: neither port nor the capture logic exists; all other behaviour is identical.

Structure
REQ-025 Package gate_selftest_pkg holds:
- the op encoding enum;
- the FSM state enum;
- the function golden_eval(op, a, b) returning the expected bit.
REQ-026 Sub-module gate_golden_model (combinational, wraps golden_eval) is instantiated once; everything else is in gate_selftest_seq.

Verification
REQ-027 Correct NAND DUT, op=0, SETTLE_CYCLES=2, one start pulse -> vectors 00,01,10,11 each held 3 cycles; done at cycle 13; pass=1; err_cnt=0.
REQ-028 NAND DUT, op=1 (AND) -> err_cnt=4, pass=0; with macro: fail_valid=1, fail_vec=0.
REQ-029 DUT output stuck at 1, op=0 -> err_cnt=1, pass=0; with macro: fail_vec=3.
REQ-030 start held high for the whole run and op toggled mid-run -> one done at cycle 13, result computed for the original op; a second run begins the cycle after DONE.
REQ-031 rst_n pulsed low at cycle 6 of a run -> immediately busy=0, dut_a=dut_b=0, err_cnt=0, no done; a fresh start then yields done 13 cycles later with pass=1.
REQ-032 SETTLE_CYCLES=1 and 15 with a correct XOR DUT, op=4 -> done at cycles 9 and 65 respectively; pass=1.

Source files
------------

// File: rtl/gate_selftest_pkg.sv
// Shared types for the gate self-test sequencer: op encoding, FSM states and
// the golden truth function used to judge the gate under test.
package gate_selftest_pkg;

    typedef enum logic [2:0] {
        OP_NAND  = 3'd0,
        OP_AND   = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_BUF_A = 3'd6,
        OP_INV_A = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    function automatic logic golden_eval(input op_e op, input logic a, input logic b);
        logic y;
        case (op)
            OP_NAND:  y = ~(a & b);
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NOR:   y = ~(a | b);
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_BUF_A: y = a;
            OP_INV_A: y = ~a;
            default:  y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gate_selftest_seq_if.sv
// Control/result and gate-stimulus bundle for gate_selftest_seq.
// fail_valid/fail_vec exist only when GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN is defined.
interface gate_selftest_seq_if;
    logic       start;
    logic [2:0] op;
    logic       dut_a;
    logic       dut_b;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
    logic       fail_valid;
    logic [1:0] fail_vec;

    modport master (
        output start, op, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_cnt, fail_valid, fail_vec
    );
    modport slave (
        input  start, op, dut_y,
        output dut_a, dut_b, busy, done, pass, err_cnt, fail_valid, fail_vec
    );
`else
    modport master (
        output start, op, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_cnt
    );
    modport slave (
        input  start, op, dut_y,
        output dut_a, dut_b, busy, done, pass, err_cnt
    );
`endif
endinterface

// File: rtl/gate_golden_model.sv
// Combinational reference for the expected gate response.
module gate_golden_model
    import gate_selftest_pkg::*;
(
    input  op_e  op,
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = golden_eval(op, a, b);
endmodule

// File: rtl/gate_selftest_seq.sv
// Exhaustive two-input gate self-test: applies vectors 00..11, holds each for
// SETTLE_CYCLES, samples dut_y against the golden model and counts mismatches.
// Optional first-failure capture via GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN.
module gate_selftest_seq
    import gate_selftest_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_selftest_seq_if.slave bus
);
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    op_e        op_q, op_d;
    logic [2:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       golden_y;
    logic       mismatch;
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
    logic       fv_q, fv_d;
    logic [1:0] fvec_q, fvec_d;
`endif

    gate_golden_model u_golden (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (golden_y)
    );

    assign mismatch = (bus.dut_y != golden_y);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;
        pass_d  = pass_q;
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
        fv_d    = fv_q;
        fvec_d  = fvec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_WAIT;
                    op_d    = op_e'(bus.op);
                    err_d   = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    cnt_d   = CNT_LOAD;
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
                    fv_d    = 1'b0;
                    fvec_d  = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_SAMPLE;
                else             cnt_d   = cnt_q - 4'd1;
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 3'd1;
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = idx_q;
                    end
`endif
                end
                // pass is resolved on entry to DONE so it is already valid alongside done
                if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = ST_WAIT;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stimulus registers follow the next index so a new vector appears on the same edge as WAIT
    always_comb begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (state_d == ST_WAIT || state_d == ST_SAMPLE) begin
            a_d = idx_d[1];
            b_d = idx_d[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_NAND;
            err_q   <= '0;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
            fv_q    <= 1'b0;
            fvec_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
`endif
        end
    end

    assign bus.dut_a   = a_q;
    assign bus.dut_b   = b_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
    assign bus.fail_valid = fv_q;
    assign bus.fail_vec   = fvec_q;
`endif

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Scoreboard bench: three sequencers (SETTLE_CYCLES 2, 1, 15) share start/op and
// each tests its own modelled gate; a monitor checks every cycle against queued expectations.
module tb_gate_selftest_seq;

    localparam int NI = 3;

    typedef struct {
        int unsigned acc;
        logic [2:0]  err;
        logic        pass;
        logic        fv;
        logic [1:0]  fvec;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_s;
    logic [2:0]  op_s;
    logic [1:0]  gmode [NI];
    logic [2:0]  gop   [NI];
    logic        busy_w [NI];
    logic        done_w [NI];
    logic        pass_w [NI];
    logic        a_w    [NI];
    logic        b_w    [NI];
    logic [2:0]  err_w  [NI];
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
    logic        fv_w   [NI];
    logic [1:0]  fvec_w [NI];
`endif

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    logic [2:0]  last_err  [NI];
    logic        last_pass [NI];
    logic        last_fv   [NI];
    logic [1:0]  last_fvec [NI];

    function automatic int unsigned settle_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // Truth table per op, bit index = {a,b}
    function automatic logic [3:0] truth(input logic [2:0] op);
        case (op)
            3'd0:    return 4'b0111;
            3'd1:    return 4'b1000;
            3'd2:    return 4'b1110;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            3'd6:    return 4'b1100;
            default: return 4'b0011;
        endcase
    endfunction

    // Gate under test: mode 0 healthy gate of type go, 1 stuck-at-0, 2 stuck-at-1
    function automatic logic gut(input logic [1:0] gm, input logic [2:0] go, input logic a, input logic b);
        logic [3:0] t;
        logic [1:0] v;
        t = truth(go);
        v = {a, b};
        case (gm)
            2'd0:    return t[v];
            2'd1:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic exp_t make_exp(input logic [2:0] op, input logic [1:0] gm,
                                      input logic [2:0] go, input int unsigned acc);
        exp_t       e;
        logic [3:0] tt;
        logic [1:0] vv;
        e.acc  = acc;
        e.err  = '0;
        e.fv   = 1'b0;
        e.fvec = '0;
        tt     = truth(op);
        for (int unsigned v = 0; v < 4; v++) begin
            vv = v[1:0];
            if (gut(gm, go, vv[1], vv[0]) !== tt[vv]) begin
                e.err = e.err + 3'd1;
                if (!e.fv) begin
                    e.fv   = 1'b1;
                    e.fvec = vv;
                end
            end
        end
        e.pass = (e.err == '0);
        return e;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned S = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        gate_selftest_seq_if bus ();
        assign bus.start = start_s;
        assign bus.op    = op_s;
        assign bus.dut_y = gut(gmode[g], gop[g], bus.dut_a, bus.dut_b);
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;
        assign pass_w[g] = bus.pass;
        assign a_w[g]    = bus.dut_a;
        assign b_w[g]    = bus.dut_b;
        assign err_w[g]  = bus.err_cnt;
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
        assign fv_w[g]   = bus.fail_valid;
        assign fvec_w[g] = bus.fail_vec;
`endif
        gate_selftest_seq #(.SETTLE_CYCLES(S)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Monitor: every negedge, compare each instance with the run window of its queue head
    always @(negedge clk) begin
        exp_t        h;
        bit          has;
        int unsigned o, s, l, idx;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                chk("rst_busy", k, 8'(busy_w[k]), 8'd0);
                chk("rst_done", k, 8'(done_w[k]), 8'd0);
                chk("rst_a",    k, 8'(a_w[k]),    8'd0);
                chk("rst_b",    k, 8'(b_w[k]),    8'd0);
                chk("rst_err",  k, 8'(err_w[k]),  8'd0);
                chk("rst_pass", k, 8'(pass_w[k]), 8'd0);
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
                chk("rst_fv",   k, 8'(fv_w[k]),   8'd0);
`endif
                case (k)
                    0:       q0.delete();
                    1:       q1.delete();
                    default: q2.delete();
                endcase
                last_err[k]  = '0;
                last_pass[k] = 1'b0;
                last_fv[k]   = 1'b0;
                last_fvec[k] = '0;
            end else begin
                has = 1'b0;
                case (k)
                    0:       if (q0.size() > 0) begin has = 1'b1; h = q0[0]; end
                    1:       if (q1.size() > 0) begin has = 1'b1; h = q1[0]; end
                    default: if (q2.size() > 0) begin has = 1'b1; h = q2[0]; end
                endcase
                s = settle_of(k);
                l = 4 * (s + 1) + 1;
                if (has && cyc >= h.acc) begin
                    o = cyc - h.acc;
                    chk("run_busy", k, 8'(busy_w[k]), 8'd1);
                    chk("run_done", k, 8'(done_w[k]), 8'(o == l - 1));
                    if (o < l - 1) begin
                        idx = o / (s + 1);
                        chk("vec_a",    k, 8'(a_w[k]),    8'((idx >> 1) & 1));
                        chk("vec_b",    k, 8'(b_w[k]),    8'(idx & 1));
                        chk("run_pass", k, 8'(pass_w[k]), 8'd0);
                    end else begin
                        chk("done_a",    k, 8'(a_w[k]),    8'd0);
                        chk("done_b",    k, 8'(b_w[k]),    8'd0);
                        chk("err_cnt",   k, 8'(err_w[k]),  8'(h.err));
                        chk("pass",      k, 8'(pass_w[k]), 8'(h.pass));
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
                        chk("fail_valid", k, 8'(fv_w[k]),  8'(h.fv));
                        chk("fail_vec",   k, 8'(fvec_w[k]), 8'(h.fvec));
`endif
                        last_err[k]  = h.err;
                        last_pass[k] = h.pass;
                        last_fv[k]   = h.fv;
                        last_fvec[k] = h.fvec;
                        case (k)
                            0:       void'(q0.pop_front());
                            1:       void'(q1.pop_front());
                            default: void'(q2.pop_front());
                        endcase
                    end
                end else begin
                    chk("idle_busy", k, 8'(busy_w[k]), 8'd0);
                    chk("idle_done", k, 8'(done_w[k]), 8'd0);
                    chk("idle_a",    k, 8'(a_w[k]),    8'd0);
                    chk("idle_b",    k, 8'(b_w[k]),    8'd0);
                    chk("hold_err",  k, 8'(err_w[k]),  8'(last_err[k]));
                    chk("hold_pass", k, 8'(pass_w[k]), 8'(last_pass[k]));
`ifdef GATE_SELFTEST_FIRST_FAIL_CAPTURE_EN
                    chk("hold_fv",   k, 8'(fv_w[k]),   8'(last_fv[k]));
                    chk("hold_fvec", k, 8'(fvec_w[k]), 8'(last_fvec[k]));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_gate(input logic [1:0] gm, input logic [2:0] go);
        for (int k = 0; k < NI; k++) begin
            gmode[k] = gm;
            gop[k]   = go;
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [1:0] gm, input logic [2:0] go);
        set_gate(gm, go);
        op_s    = op;
        start_s = 1'b1;
        for (int k = 0; k < NI; k++) push(k, make_exp(op, gm, go, cyc + 1));
        tick();
        start_s = 1'b0;
        op_s    = 3'($urandom_range(0, 7));
        repeat (70) tick();
    endtask

    initial begin
        int unsigned p;
        rst_n   = 1'b0;
        start_s = 1'b0;
        op_s    = '0;
        set_gate(2'd0, 3'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        run(3'd0, 2'd0, 3'd0);   // healthy NAND, op NAND
        run(3'd1, 2'd0, 3'd0);   // NAND gate judged as AND
        run(3'd0, 2'd2, 3'd0);   // stuck-at-1, op NAND
        run(3'd4, 2'd0, 3'd4);   // healthy XOR
        run(3'd2, 2'd1, 3'd0);   // stuck-at-0, op OR

        // start held through a whole run while op wanders
        set_gate(2'd0, 3'd0);
        p       = cyc + 1;
        start_s = 1'b1;
        for (int unsigned j = 0; j < 15; j++) begin
            op_s = (j == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            for (int k = 0; k < NI; k++)
                if (j % (4 * (settle_of(k) + 1) + 2) == 0)
                    push(k, make_exp(op_s, 2'd0, 3'd0, p + j));
            tick();
        end
        start_s = 1'b0;
        repeat (70) tick();

        // reset in cycle 6 of a run
        set_gate(2'd0, 3'd0);
        op_s    = 3'd0;
        start_s = 1'b1;
        for (int k = 0; k < NI; k++) push(k, make_exp(3'd0, 2'd0, 3'd0, cyc + 1));
        tick();
        start_s = 1'b0;
        repeat (4) tick();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run(3'd0, 2'd0, 3'd0);

        for (int i = 0; i < 20; i++)
            run(3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)));

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
